// File: rtl/census_window_gen.sv
// census_window_gen
// Streaming 3x3 window generator feeding the census compare stage.
// Accepts one raster-order pixel per in_valid cycle, keeps the two previous
// image rows in line buffers and presents the full 3x3 neighbourhood of every
// interior pixel, one cycle after the accept of its bottom-right pixel.
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       in_pixel is consumed this cycle
//   in_sof         with in_valid: current pixel is frame position (0,0)
//   in_pixel       raster-order input pixel
//   out_valid      window outputs hold a valid interior window (1-cycle strobe)
//   out_last       with out_valid: final window of the frame
//   pixel_0..8     window, row-major; pixel_0 top-left, pixel_8 newest pixel
module census_window_gen #(
  parameter int DATA_W = 11,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] pixel_0,
  output logic [DATA_W-1:0] pixel_1,
  output logic [DATA_W-1:0] pixel_2,
  output logic [DATA_W-1:0] pixel_3,
  output logic [DATA_W-1:0] pixel_4_center,
  output logic [DATA_W-1:0] pixel_5,
  output logic [DATA_W-1:0] pixel_6,
  output logic [DATA_W-1:0] pixel_7,
  output logic [DATA_W-1:0] pixel_8
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row_eff;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;

  logic [DATA_W-1:0] lb_top [IMG_W];
  logic [DATA_W-1:0] lb_mid [IMG_W];
  logic [DATA_W-1:0] top_rd;
  logic [DATA_W-1:0] mid_rd;

  logic [DATA_W-1:0] win [9];

  logic win_valid;
  logic win_last;

  // A start-of-frame accept is handled as position (0,0) regardless of the
  // counters; stale line-buffer rows are then masked by the row >= 2 gate.
  always_comb begin
    col_eff = in_sof ? '0 : col;
    row_eff = in_sof ? '0 : row;
    col_nxt = col_eff + CW'(1);
    row_nxt = row_eff;
    if (col_eff == COL_MAX) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_MAX) ? '0 : row_eff + RW'(1);
    end
  end

  assign top_rd    = lb_top[col_eff];
  assign mid_rd    = lb_mid[col_eff];
  assign win_valid = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
  assign win_last  = (row_eff == ROW_MAX) && (col_eff == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Line buffers are plain storage: no reset, read-before-write at col_eff.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col_eff] <= mid_rd;
      lb_mid[col_eff] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= in_valid && win_valid;
      out_last  <= in_valid && win_last;
      if (in_valid) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= top_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= mid_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= in_pixel;
      end
    end
  end

  assign pixel_0        = win[0];
  assign pixel_1        = win[1];
  assign pixel_2        = win[2];
  assign pixel_3        = win[3];
  assign pixel_4_center = win[4];
  assign pixel_5        = win[5];
  assign pixel_6        = win[6];
  assign pixel_7        = win[7];
  assign pixel_8        = win[8];

endmodule

// File: tb/tb_census_window_gen.sv
module tb_census_window_gen;
  localparam int DW = 11;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] pix [9];

  int checks = 0;
  int errors = 0;

  // reference model: image stored by position, window cut out of it
  int            mrow = 0;
  int            mcol = 0;
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] exp_win [9];
  bit            held_ok = 0;
  int            obs_cnt = 0;
  int            last_cnt = 0;

  census_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_last(out_last),
    .pixel_0(pix[0]), .pixel_1(pix[1]), .pixel_2(pix[2]), .pixel_3(pix[3]),
    .pixel_4_center(pix[4]), .pixel_5(pix[5]), .pixel_6(pix[6]),
    .pixel_7(pix[7]), .pixel_8(pix[8])
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_last"}, {31'd0, out_last}, 0);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_pixel_%0d", tag, k), {21'd0, pix[k]}, 0);
  endtask

  function automatic logic [DW-1:0] pixval(int mode, int r, int c);
    case (mode)
      0:       return DW'(16 * r + c);
      1:       return DW'(16 * r + c + 'h100);
      2:       return ((r + c) % 2) ? 11'h7FF : 11'h000;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic step(bit v, bit s, logic [DW-1:0] px);
    bit ev, el;
    int r, c, idx;
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    @(posedge clk);
    #1;
    if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      r = mrow;
      c = mcol;
      img[r][c] = px;
      ev = (r >= 2) && (c >= 2);
      el = (r == H - 1) && (c == W - 1);
      if (ev) for (int k = 0; k < 9; k++) exp_win[k] = img[r - 2 + k / 3][c - 2 + k % 3];
      held_ok = ev;
      idx  = (r * W + c + 1) % (W * H);
      mrow = idx / W;
      mcol = idx % W;
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("out_last", {31'd0, out_last}, {31'd0, el});
      if (ev) for (int k = 0; k < 9; k++) chk($sformatf("pixel_%0d", k), {21'd0, pix[k]}, {21'd0, exp_win[k]});
    end else begin
      chk("bubble_valid", {31'd0, out_valid}, 0);
      chk("bubble_last", {31'd0, out_last}, 0);
      if (held_ok) for (int k = 0; k < 9; k++) chk($sformatf("hold_pixel_%0d", k), {21'd0, pix[k]}, {21'd0, exp_win[k]});
    end
    if (out_valid === 1'b1) obs_cnt++;
    if (out_last === 1'b1) last_cnt++;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic feed(int r, int c, int mode, bit s, bit bub);
    if (bub) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
    step(1'b1, s, pixval(mode, r, c));
  endtask

  task automatic run_frame(int mode, bit bub, bit sof);
    obs_cnt  = 0;
    last_cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        feed(r, c, mode, sof && r == 0 && c == 0, bub);
        if (mode == 0 && r == 2 && c == 2) begin
          chk("basic_valid", {31'd0, out_valid}, 1);
          chk("basic_p0", {21'd0, pix[0]}, 'h00);
          chk("basic_center", {21'd0, pix[4]}, 'h11);
          chk("basic_p8", {21'd0, pix[8]}, 'h22);
          chk("basic_p2", {21'd0, pix[2]}, 'h02);
          chk("basic_p6", {21'd0, pix[6]}, 'h20);
        end
        if (mode == 0 && out_last === 1'b1) chk("last_center", {21'd0, pix[4]}, 'h23);
        if (mode == 1 && r == 2 && c == 2) chk("b2b_first_p0", {21'd0, pix[0]}, 'h100);
        if (mode == 2 && r == H - 1 && c == W - 1) begin
          chk("width_center", {21'd0, pix[4]}, 'h7FF);
          chk("width_p0", {21'd0, pix[0]}, 'h7FF);
          chk("width_p8", {21'd0, pix[8]}, 'h7FF);
        end
      end
    end
    chk("window_count", obs_cnt, NWIN);
    chk("last_count", last_cnt, 1);
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b1);   // basic
    run_frame(0, 1'b1, 1'b1);   // random bubbles, same windows
    run_frame(1, 1'b0, 1'b1);   // back-to-back, different data

    // resync: partial frame, then in_sof at (2,3)
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        if (r < 2 || c < 3) feed(r, c, 3, r == 0 && c == 0, 1'b1);
    run_frame(1, 1'b1, 1'b1);

    // reset mid-frame at (3,1)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 2) feed(r, c, 3, r == 0 && c == 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mrow    = 0;
    mcol    = 0;
    held_ok = 0;
    run_frame(3, 1'b1, 1'b0);   // no sof: first pixel after reset is (0,0)

    run_frame(2, 1'b1, 1'b1);   // checkerboard full-width
    run_frame(3, 1'b1, 1'b1);   // random data

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
